// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : y86_pkg
//  Description : Shared Y86-64 definitions: icode values, the maximum
//                instruction length in bytes and the byte loader state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam int MAX_INSTR_BYTES = 10;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_FETCH = 2'd1,
        LD_DONE  = 2'd2
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/ilen_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ilen_decode
//  Description : Combinational icode -> instruction length decoder.
//                Unknown icodes report valid=0 and a length of 1.
//  Ports       : icode (in, 4)  high nibble of instruction byte 0
//                len   (out, 4) instruction length in bytes
//                valid (out, 1) icode is a defined Y86-64 instruction
//  Revision    : 1.0 - initial release
// ============================================================================
module ilen_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len,
    output logic       valid
);

    always_comb begin
        len   = 4'd1;
        valid = 1'b1;
        case (icode)
            ICODE_HALT, ICODE_NOP, ICODE_RET:                len = 4'd1;
            ICODE_RRMOVQ, ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ: len = 4'd2;
            ICODE_JXX, ICODE_CALL:                           len = 4'd9;
            ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ:        len = 4'd10;
            default: begin
                len   = 4'd1;
                valid = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_byte_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_byte_loader
//  Description : Reads a byte-wide synchronous instruction memory one byte
//                per cycle starting at a requested PC and presents the
//                80-bit big-first window {mem[PC], ..., mem[PC+9]} with a
//                valid/ready handshake, a range error and an icode error.
//  Ports       : clk, rst_n (async, active low)
//                req_valid/req_pc/req_ready   PC request handshake
//                flush                        abort current fetch/result
//                mem_rd_en/mem_addr/mem_rdata synchronous memory port
//                instr/instr_pc/instr_len     presented instruction window
//                instr_valid/instr_ready      result handshake
//                mem_error, instr_err         window flags
//  Options     : ILEN_EARLY_EN - stop after the length decoded from byte 0
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_byte_loader
    import y86_pkg::*;
#(
    parameter  int MEM_DEPTH = 1024,
    parameter  int PC_W      = 64,
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic [PC_W-1:0] req_pc,
    output logic            req_ready,
    input  logic            flush,
    output logic            mem_rd_en,
    output logic [AW-1:0]   mem_addr,
    input  logic [7:0]      mem_rdata,
    output logic [0:79]     instr,
    output logic [PC_W-1:0] instr_pc,
    output logic [3:0]      instr_len,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic            mem_error,
    output logic            instr_err
);

    localparam logic [3:0]  C_MAX_LEN = 4'(MAX_INSTR_BYTES);
    localparam logic [PC_W:0] C_DEPTH = (PC_W+1)'(MEM_DEPTH);

    loader_state_t   r_state;
    logic [PC_W-1:0] r_base;
    logic            r_issuing;     // a slot is on the memory port this cycle
    logic [3:0]      r_issue_idx;
    logic            r_cap_valid;   // mem_rdata carries slot r_cap_idx
    logic [3:0]      r_cap_idx;
    logic            r_cap_oor;     // that slot was out of range (no read)
    logic [3:0]      r_cap_cnt;
    logic [0:79]     r_instr;
    logic [PC_W-1:0] r_instr_pc;
    logic [3:0]      r_len;         // byte limit; final value is instr_len
    logic            r_instr_valid;
    logic            r_mem_error;
    logic            r_instr_err;
    logic            r_mem_rd_en;
    logic [AW-1:0]   r_mem_addr;

    logic [7:0]      w_cap_byte;
    logic            w_cap_first;
    logic [3:0]      w_dec_len;
    logic            w_dec_valid;
    logic [3:0]      w_limit;
    logic [PC_W-1:0] w_base_sel;
    logic [3:0]      w_next_idx;
    logic [PC_W:0]   w_slot_sum;
    logic            w_slot_oor;
    logic [3:0]      w_cap_cnt_next;

    // Out-of-range slots never touch memory and read as zero.
    assign w_cap_byte  = r_cap_oor ? 8'h00 : mem_rdata;
    assign w_cap_first = r_cap_valid && (r_cap_idx == 4'd0);

    ilen_decode u_ilen_decode (
        .icode (w_cap_byte[7:4]),
        .len   (w_dec_len),
        .valid (w_dec_valid)
    );

`ifdef ILEN_EARLY_EN
    // While byte 0 is on mem_rdata the decoded length already bounds the
    // next issue, so at most slot 1 is read beyond a 1-byte instruction.
    assign w_limit = w_cap_first ? w_dec_len : r_len;
`else
    logic w_unused_len;
    assign w_unused_len = ^w_dec_len;
    assign w_limit      = C_MAX_LEN;
`endif

    // Address of the slot that will be presented after the coming edge.
    // The extra top bit catches a PC add that wraps past 2^PC_W.
    assign w_base_sel     = (r_state == LD_IDLE) ? req_pc : r_base;
    assign w_next_idx     = (r_state == LD_IDLE) ? 4'd0 : (r_issue_idx + 4'd1);
    assign w_slot_sum     = {1'b0, w_base_sel} + {{(PC_W-3){1'b0}}, w_next_idx};
    assign w_slot_oor     = (w_slot_sum >= C_DEPTH);
    assign w_cap_cnt_next = r_cap_cnt + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= LD_IDLE;
            r_base        <= '0;
            r_issuing     <= 1'b0;
            r_issue_idx   <= 4'd0;
            r_cap_valid   <= 1'b0;
            r_cap_idx     <= 4'd0;
            r_cap_oor     <= 1'b0;
            r_cap_cnt     <= 4'd0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_len         <= 4'd0;
            r_instr_valid <= 1'b0;
            r_mem_error   <= 1'b0;
            r_instr_err   <= 1'b0;
            r_mem_rd_en   <= 1'b0;
            r_mem_addr    <= '0;
        end else begin
            case (r_state)
                LD_IDLE: begin
                    if (req_valid) begin
                        r_base      <= req_pc;
                        r_instr_pc  <= req_pc;
                        r_instr     <= '0;
                        r_mem_error <= 1'b0;
                        r_instr_err <= 1'b0;
                        r_len       <= C_MAX_LEN;
                        r_cap_cnt   <= 4'd0;
                        r_cap_valid <= 1'b0;
                        r_issue_idx <= 4'd0;
                        r_issuing   <= 1'b1;
                        r_mem_rd_en <= ~w_slot_oor;
                        r_mem_addr  <= w_slot_sum[AW-1:0];
                        r_state     <= LD_FETCH;
                    end
                end

                LD_FETCH: begin
                    if (flush) begin
                        r_state       <= LD_IDLE;
                        r_instr_valid <= 1'b0;
                        r_issuing     <= 1'b0;
                        r_mem_rd_en   <= 1'b0;
                        r_cap_valid   <= 1'b0;
                    end else begin
                        // The slot on the port now is sampled by memory at
                        // this edge; its data is captured one edge later.
                        r_cap_valid <= r_issuing;
                        r_cap_idx   <= r_issue_idx;
                        r_cap_oor   <= ~r_mem_rd_en;

                        if (r_issuing && (w_next_idx < w_limit)) begin
                            r_issue_idx <= w_next_idx;
                            r_mem_rd_en <= ~w_slot_oor;
                            r_mem_addr  <= w_slot_sum[AW-1:0];
                        end else begin
                            r_issuing   <= 1'b0;
                            r_mem_rd_en <= 1'b0;
                        end

                        if (r_cap_valid) begin
                            r_instr[8*r_cap_idx +: 8] <= w_cap_byte;
                            r_mem_error <= r_mem_error | r_cap_oor;
                            r_cap_cnt   <= w_cap_cnt_next;
                            if (w_cap_first) begin
                                r_instr_err <= ~w_dec_valid;
                                r_len       <= w_limit;
                            end
                            if (w_cap_cnt_next == w_limit) begin
                                r_state       <= LD_DONE;
                                r_instr_valid <= 1'b1;
                                r_issuing     <= 1'b0;
                                r_mem_rd_en   <= 1'b0;
                                r_cap_valid   <= 1'b0;
                            end
                        end
                    end
                end

                LD_DONE: begin
                    if (flush || instr_ready) begin
                        r_state       <= LD_IDLE;
                        r_instr_valid <= 1'b0;
                    end
                end

                default: begin
                    r_state       <= LD_IDLE;
                    r_instr_valid <= 1'b0;
                    r_issuing     <= 1'b0;
                    r_mem_rd_en   <= 1'b0;
                    r_cap_valid   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = (r_state == LD_IDLE) && rst_n;
    assign mem_rd_en   = r_mem_rd_en;
    assign mem_addr    = r_mem_addr;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_len   = r_len;
    assign instr_valid = r_instr_valid;
    assign mem_error   = r_mem_error;
    assign instr_err   = r_instr_err;

endmodule
`default_nettype wire
